// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one ram_reader between NUM_REQ burst read requesters.
// Optional per-word watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_read_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]       req_len,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic                       rsp_last,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       rd_cmd_valid,
  input  logic                       rd_cmd_ready,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic                       rd_data_valid,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state;
  logic [OWN_W-1:0]       owner;
  logic [OWN_W-1:0]       last_owner;
  logic [ADDR_WIDTH-1:0]  base;
  logic [3:0]             len;
  logic [3:0]             word_idx;
  logic [3:0]             nxt_idx;
  logic                   gnt_hit;
  logic [OWN_W-1:0]       gnt_sel;
  logic [OWN_W-1:0]       cand;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  // Watchdog compiled out: flag is constant 0; the expression only anchors the parameter.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  assign nxt_idx = word_idx + 4'd1;

  // Round-robin search starting just after the previous owner
  always_comb begin
    gnt_hit = 1'b0;
    gnt_sel = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OWN_W'((int'(last_owner) + k) % NUM_REQ);
      if (!gnt_hit && req_valid[cand]) begin
        gnt_hit = 1'b1;
        gnt_sel = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= '0;
      last_owner   <= OWN_W'(NUM_REQ - 1);
      base         <= '0;
      len          <= '0;
      word_idx     <= '0;
      req_ack      <= '0;
      rsp_valid    <= '0;
      rsp_last     <= 1'b0;
      rsp_data     <= '0;
      rd_cmd_valid <= 1'b0;
      rd_addr      <= '0;
      busy         <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      to_cnt       <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_last  <= 1'b0;
      case (state)
        IDLE: begin
          // The ack cycle stays in IDLE; the pending ack blocks a second grant
          if (|req_ack) begin
            state        <= ISSUE;
            busy         <= 1'b1;
            rd_cmd_valid <= 1'b1;
            rd_addr      <= base;
          end else if (gnt_hit) begin
            owner             <= gnt_sel;
            last_owner        <= gnt_sel;
            base              <= req_addr[int'(gnt_sel)*ADDR_WIDTH +: ADDR_WIDTH];
            len               <= req_len[int'(gnt_sel)*4 +: 4];
            word_idx          <= '0;
            req_ack[gnt_sel]  <= 1'b1;
          end
        end
        ISSUE: begin
          if (rd_cmd_ready) begin
            rd_cmd_valid <= 1'b0;
            state        <= WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
            to_cnt       <= '0;
`endif
          end
        end
        WAIT: begin
          if (rd_data_valid) begin
            rsp_valid[owner] <= 1'b1;
            rsp_data         <= rd_data;
            if (word_idx == len) begin
              rsp_last <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              word_idx     <= nxt_idx;
              rd_addr      <= base + ADDR_WIDTH'(nxt_idx);
              rd_cmd_valid <= 1'b1;
              state        <= ISSUE;
            end
`ifdef RAM_ARB_TIMEOUT_EN
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err      <= 1'b1;
            rsp_valid[owner] <= 1'b1;
            rsp_last         <= 1'b1;
            rsp_data         <= '0;
            state            <= IDLE;
            busy             <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_read_arbiter.md
RAM_READ_ARBITER -- requirements
Module: ram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of read requesters: embedding fetch, weight fetch and logit fetch.
REQ-002 Parameter ADDR_WIDTH, default 27, DDR3 word address width.
REQ-003 Parameter DATA_WIDTH, default 16, read word width.
REQ-004 Parameter TIMEOUT_CYCLES, default 1023, watchdog limit per word.
REQ-005 clk  in  1  single clock, which is the MIG ui_clk domain.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  NUM_REQ  requester i wants a burst.
REQ-008 req_addr  in  NUM_REQ*ADDR_WIDTH  burst base address; slice i belongs to requester i.
REQ-009 req_len  in  NUM_REQ*4  burst length minus 1 (1..16 words); slice i belongs to requester i.
REQ-010 req_ack  out  NUM_REQ  one-cycle pulse when the burst of requester i is accepted.
REQ-011 rsp_valid  out  NUM_REQ  a returned word is valid for the owner.
REQ-012 rsp_last  out  1  qualifies the last word of a burst.
REQ-013 rsp_data  out  DATA_WIDTH  returned word.
REQ-014 rd_cmd_valid  out  1  read command to ram_reader.
REQ-015 rd_cmd_ready  in  1  ram_reader accepts the command.
REQ-016 rd_addr  out  ADDR_WIDTH  read address.
REQ-017 rd_data_valid  in  1  ram_reader data strobe.
REQ-018 rd_data  in  DATA_WIDTH  ram_reader data.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 timeout_err  out  1  sticky watchdog flag.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-022 In IDLE with any req_valid high, the arbiter SHALL grant round-robin, searching from (last_owner+1) mod NUM_REQ.
  - On grant: latch owner, base address and length; clear word_idx; pulse req_ack[owner]; go to ISSUE on the next cycle.
  - After reset, last_owner = NUM_REQ-1, so requester 0 has first priority.
REQ-023 In ISSUE, rd_cmd_valid SHALL be 1 and rd_addr SHALL equal (base + word_idx) truncated to ADDR_WIDTH bits, so addresses wrap modulo 2^ADDR_WIDTH.
  - rd_cmd_valid and rd_addr SHALL hold until rd_cmd_ready is high; then go to WAIT.
REQ-024 Exactly one read SHALL be outstanding at a time, and rd_cmd_valid SHALL be 0 outside ISSUE.
REQ-025 In WAIT, on rd_data_valid the arbiter SHALL, on the next cycle, register rsp_data = rd_data and drive rsp_valid[owner] = 1 for one cycle.
  - If word_idx == len: assert rsp_last and go to IDLE.
  - Otherwise: increment word_idx and go to ISSUE.
REQ-026 A rd_data_valid arriving outside WAIT SHALL be ignored and no rsp_valid produced.
REQ-027 Changes to req_valid, req_addr or req_len after the ack SHALL NOT affect the burst in progress.
REQ-028 A request arriving during a burst SHALL wait; the earliest it can be granted is the cycle after the arbiter returns to IDLE.
REQ-029 Latency: req_ack 1 cycle after req_valid in IDLE; first rd_cmd_valid 1 cycle after req_ack; rsp_valid 1 cycle after rd_data_valid.

Reset
REQ-030 While reset is high, asynchronously:
  - state = IDLE; last_owner = NUM_REQ-1; word_idx = 0.
  - All outputs = 0, including rd_addr, rsp_data and timeout_err.
REQ-031 A reset asserted mid-burst SHALL abort the burst; no response is produced for in-flight data.

Configuration
REQ-032 With macro RAM_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT, cleared on each word.
  - If it reaches TIMEOUT_CYCLES: set timeout_err (sticky until reset); pulse rsp_valid[owner] with rsp_last = 1 and rsp_data = 0; return to IDLE with last_owner advanced.
REQ-033 With RAM_ARB_TIMEOUT_EN undefined, WAIT SHALL last indefinitely, timeout_err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-034 req_valid = 3'b001, addr 0x000100, len 15; ram returns 16 words with 2-cycle latency -> rd_addr 0x100..0x10F in order, 16 rsp_valid[0] pulses, rsp_last only on the 16th.
REQ-035 req_valid = 3'b111 held continuously, all len 0 -> grants in order 0, 1, 2, 0, and each req_ack is a single cycle.
REQ-036 addr 0x7FFFFFE, len 3 -> rd_addr sequence 0x7FFFFFE, 0x7FFFFFF, 0x0000000, 0x0000001.
REQ-037 rd_cmd_ready held low for 5 cycles -> rd_cmd_valid and rd_addr stable throughout; a stray rd_data_valid in IDLE produces no rsp_valid.
REQ-038 reset pulsed on the 3rd word of an 8-word burst -> all outputs 0 immediately, no further rsp_valid, and the next grant goes to requester 0.
REQ-039 With RAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no rd_data_valid -> after 8 WAIT cycles: timeout_err = 1, rsp_last pulse with rsp_data 0, state IDLE.
